// File: rtl/mux_resp_fifo.sv
// Capture FIFO behind the two-input priority data mux.
// Buffers mux responses and replays them over valid/ready.
module mux_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_resp,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, drop;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign out_valid = !empty;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

  assign pop  = out_valid && out_ready;
  assign push = in_resp && (!full || pop);
  assign drop = in_resp && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // a drop in the same cycle outranks the clear
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_mux_resp_fifo.sv
// Directed vector bench for mux_resp_fifo.
// Table of per-cycle stimulus and post-edge expectations.
module tb_mux_resp_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_resp;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clr_ovf;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mux_resp_fifo #(.DEPTH(4), .WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_resp   (in_resp),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic        resp;
    logic [31:0] data;
    logic        ready;
    logic        clr;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        e_ovf;
    logic [31:0] e_data;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic r, input logic rs,
                     input logic [31:0] d, input logic rd, input logic c,
                     input logic [2:0] ec, input logic ef, input logic eo,
                     input logic [31:0] ed);
    vec_t v;
    v.name = nm; v.rst_n = r; v.resp = rs; v.data = d;
    v.ready = rd; v.clr = c; v.e_cnt = ec; v.e_full = ef;
    v.e_ovf = eo; v.e_data = ed;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [2:0] ec,
                       input logic ef, input logic eo,
                       input logic [31:0] ed);
    logic [38:0] act, exp;
    logic ev;
    ev  = (ec != 3'd0);
    act = {count, out_valid, empty, full, overflow, out_data};
    exp = {ec, ev, !ev, ef, eo, ed};
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got cnt=%0d v=%b e=%b f=%b ovf=%b data=%h, want cnt=%0d v=%b e=%b f=%b ovf=%b data=%h",
                  nm, count, out_valid, empty, full, overflow, out_data,
                  ec, ev, !ev, ef, eo, ed);
  endtask

  task automatic drive(input logic r, input logic rs, input logic [31:0] d,
                       input logic rd, input logic c);
    @(negedge clk);
    rst_n = r; in_resp = rs; in_data = d; out_ready = rd; clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_resp = 1'b0; in_data = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;

    //   name        rst resp data          rdy clr cnt full ovf out_data
    add("rst0",      0, 1, 32'h11,        0, 0, 0, 0, 0, 32'h0);
    add("rst1",      0, 1, 32'h22,        1, 1, 0, 0, 0, 32'h0);
    add("push_dead", 1, 1, 32'hDEADBEEF,  0, 0, 1, 0, 0, 32'hDEADBEEF);
    add("pop_dead",  1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0);
    add("fill1",     1, 1, 32'h1,         0, 0, 1, 0, 0, 32'h1);
    add("fill2",     1, 1, 32'h2,         0, 0, 2, 0, 0, 32'h1);
    add("fill3",     1, 1, 32'h3,         0, 0, 3, 0, 0, 32'h1);
    add("fill4",     1, 1, 32'h4,         0, 0, 4, 1, 0, 32'h1);
    add("drop5",     1, 1, 32'h5,         0, 0, 4, 1, 1, 32'h1);
    add("drain1",    1, 0, 32'h0,         1, 0, 3, 0, 1, 32'h2);
    add("drain2",    1, 0, 32'h0,         1, 0, 2, 0, 1, 32'h3);
    add("drain3",    1, 0, 32'h0,         1, 0, 1, 0, 1, 32'h4);
    add("drain4",    1, 0, 32'h0,         1, 0, 0, 0, 1, 32'h0);
    add("empty_rdy", 1, 0, 32'h0,         1, 0, 0, 0, 1, 32'h0);
    add("clr_ovf",   1, 0, 32'h0,         0, 1, 0, 0, 0, 32'h0);
    add("refill1",   1, 1, 32'h10,        0, 0, 1, 0, 0, 32'h10);
    add("refill2",   1, 1, 32'h11,        0, 0, 2, 0, 0, 32'h10);
    add("refill3",   1, 1, 32'h12,        0, 0, 3, 0, 0, 32'h10);
    add("refill4",   1, 1, 32'h13,        0, 0, 4, 1, 0, 32'h10);
    add("full_pp",   1, 1, 32'hA5A5A5A5,  1, 0, 4, 1, 0, 32'h11);
    add("drop_clr",  1, 1, 32'hBAD,       0, 1, 4, 1, 1, 32'h11);
    add("clr_only",  1, 0, 32'h0,         0, 1, 4, 1, 0, 32'h11);
    add("out12",     1, 0, 32'h0,         1, 0, 3, 0, 0, 32'h12);
    add("out13",     1, 0, 32'h0,         1, 0, 2, 0, 0, 32'h13);
    add("outA5",     1, 0, 32'h0,         1, 0, 1, 0, 0, 32'hA5A5A5A5);
    add("outnone",   1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0);
    add("pre_rst",   1, 1, 32'h77,        0, 0, 1, 0, 0, 32'h77);
    add("mid_rst",   0, 1, 32'h88,        1, 0, 0, 0, 0, 32'h0);
    add("post_rst",  1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0);

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].resp, vq[i].data, vq[i].ready, vq[i].clr);
      check(vq[i].name, vq[i].e_cnt, vq[i].e_full, vq[i].e_ovf,
            vq[i].e_data);
    end

    // streaming: each word appears one edge after its push, count stays 1
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'(i), 1'b1, 1'b0);
      check($sformatf("wrap%0d", i), 3'd1, 1'b0, 1'b0, 32'(i));
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_end", 3'd0, 1'b0, 1'b0, 32'h0);

    // state after wrap: ptrs at 2/2; fill across the wrap point
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      check($sformatf("wfill%0d", i), 3'(i + 1), i == 3, 1'b0, 32'h100);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      check($sformatf("wdrain%0d", i), 3'(3 - i), 1'b0, 1'b0,
            i == 3 ? 32'h0 : 32'h101 + 32'(i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mux_resp_fifo.md
# mux_resp_fifo

Registered capture buffer sitting directly downstream of the two-input priority data mux. Each cycle the mux asserts its valid response, the block latches the 32-bit selected word into a small circular FIFO. The buffered words are then presented to the consumer over a valid/ready handshake, decoupling the combinational mux from a consumer that may stall. Occupancy, full/empty status and a sticky overflow flag are exported for debug and flow control.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, minimum 2
- WIDTH, 32, data word width; matches the mux output word
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- in_data  input  WIDTH  selected word from the mux (mux out_data)
- in_resp  input  1  mux valid response (mux out_resp); 1 = in_data is valid this cycle
- out_data  output  WIDTH  head-of-FIFO word; 0 when empty
- out_valid  output  1  head word valid (= not empty)
- out_ready  input  1  consumer accepts head word this cycle
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky; a valid in_resp word was dropped
- clr_ovf  input  1  clears overflow on next edge

## Operation
- Storage: DEPTH x WIDTH register array, write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits, wrap modulo DEPTH; separate count register.
- push = in_resp && (!full || pop). pop = out_valid && out_ready.
- On push: mem[wr_ptr] <= in_data; wr_ptr increments (wraps DEPTH-1 -> 0).
- On pop: rd_ptr increments (wraps).
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: push accepted; count stays DEPTH.
- Empty: out_valid = 0, pop impossible; out_ready ignored. No bypass: a word pushed into an empty FIFO is not visible on the same cycle.
- Drop: in_resp = 1 while full and no pop -> word discarded, pointers/count unchanged, overflow <= 1.
- overflow: set has priority over clr_ovf when both occur in the same cycle; otherwise clr_ovf = 1 clears it.
- out_data = mem[rd_ptr] when !empty, else all zeros (matches mux default-zero output).
- full, empty and out_valid are decoded from the count register; no combinational path from in_resp/in_data to any output.
- Only out_ready -> pop reaches internal state; out_ready has no combinational path to outputs.

## Timing
- Reset (rst_n = 0 at rising clk): wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0; hence out_valid = 0, empty = 1, full = 0, out_data = 0. Memory contents not reset.
- Reset mid-operation discards all buffered words; in_resp, out_ready and clr_ovf are ignored during reset cycles.
- Write latency: word with in_resp = 1 at edge N appears on out_data / out_valid = 1 after edge N (one cycle) if the FIFO was empty.
- Read: handshake completes at the edge where out_valid && out_ready; next entry (or 0 / out_valid = 0) is presented after that edge.
- Sustained throughput: one push and one pop per cycle at any occupancy, including full.
- count, full, empty and overflow all update on the same edge as the push/pop/drop that causes them.

## Test plan
- Reset: hold rst_n = 0 two cycles with in_resp = 1 -> after release count = 0, empty = 1, out_valid = 0, out_data = 0, overflow = 0.
- Single pass: push 0xDEADBEEF with out_ready = 0 -> next cycle out_valid = 1, out_data = 0xDEADBEEF, count = 1. Then out_ready = 1 for one cycle -> empty = 1, out_data = 0.
- Fill and overflow: push 0x1, 0x2, 0x3, 0x4, 0x5 with out_ready = 0 -> full = 1, count = 4, overflow = 1. Drain yields 0x1..0x4 in order; 0x5 is lost.
- Full with simultaneous push/pop: at full, in_resp = 1 with 0xA5A5A5A5 and out_ready = 1 -> count stays 4, overflow stays 0, 0xA5A5A5A5 emerges fifth.
- Wrap-around: 10 cycles of continuous push of 0..9 with out_ready = 1 -> outputs 0..9 each one cycle after push, count never exceeds 1, pointers wrap twice.
- Overflow clear: with overflow = 1, clr_ovf = 1 alone -> overflow = 0 next cycle. clr_ovf = 1 together with a drop -> overflow remains 1.
